// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: register indices, instruction codes and the default datapath width.
package y86_pkg;

   localparam int unsigned DATA_W = 64;

   localparam logic [3:0] RRAX  = 4'h0;
   localparam logic [3:0] RRCX  = 4'h1;
   localparam logic [3:0] RRDX  = 4'h2;
   localparam logic [3:0] RRBX  = 4'h3;
   localparam logic [3:0] RRSP  = 4'h4;
   localparam logic [3:0] RRBP  = 4'h5;
   localparam logic [3:0] RRSI  = 4'h6;
   localparam logic [3:0] RRDI  = 4'h7;
   localparam logic [3:0] RR8   = 4'h8;
   localparam logic [3:0] RR9   = 4'h9;
   localparam logic [3:0] RR10  = 4'hA;
   localparam logic [3:0] RR11  = 4'hB;
   localparam logic [3:0] RR12  = 4'hC;
   localparam logic [3:0] RR13  = 4'hD;
   localparam logic [3:0] RR14  = 4'hE;
   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

endpackage

// File: rtl/y86_rf_scoreboard.sv
// Per-register busy tracking for in-flight producers and the RAW hazard flag for pipeline control.
module y86_rf_scoreboard #(
   parameter int unsigned NREGS  = 15,
   parameter int unsigned IDX_W  = 4,
   parameter bit          BYPASS = 1'b1
) (
   input  logic             clk_i,
   input  logic             res_i,
   input  logic             rd_en_i,
   input  logic [IDX_W-1:0] src_a_i,
   input  logic [IDX_W-1:0] src_b_i,
   input  logic             we_e_i,
   input  logic [IDX_W-1:0] dst_e_i,
   input  logic             we_m_i,
   input  logic [IDX_W-1:0] dst_m_i,
   input  logic             iss_en_i,
   input  logic [IDX_W-1:0] iss_dst_e_i,
   input  logic [IDX_W-1:0] iss_dst_m_i,
   output logic             hazard_o
);

   localparam logic [IDX_W-1:0] NRegsIdx = IDX_W'(NREGS);

   logic [NREGS-1:0] busy_q, busy_d;
   logic             iss_e_ok, iss_m_ok;
   logic             set_i, clr_i;
   logic             pend_a, pend_b;
   logic             byp_a, byp_b;

   always_comb begin
      iss_e_ok = iss_en_i && (iss_dst_e_i < NRegsIdx);
      iss_m_ok = iss_en_i && (iss_dst_m_i < NRegsIdx);
      busy_d   = busy_q;
      set_i    = 1'b0;
      clr_i    = 1'b0;
      for (int i = 0; i < int'(NREGS); i++) begin
         set_i = (iss_e_ok && (iss_dst_e_i == IDX_W'(i))) ||
                 (iss_m_ok && (iss_dst_m_i == IDX_W'(i)));
         clr_i = (we_e_i && (dst_e_i == IDX_W'(i))) ||
                 (we_m_i && (dst_m_i == IDX_W'(i)));
         // An issue in the same cycle as a retiring write belongs to a newer producer.
         busy_d[i] = set_i | (busy_q[i] & ~clr_i);
      end
   end

   always_comb begin
      byp_a  = BYPASS && ((we_e_i && (dst_e_i == src_a_i)) || (we_m_i && (dst_m_i == src_a_i)));
      byp_b  = BYPASS && ((we_e_i && (dst_e_i == src_b_i)) || (we_m_i && (dst_m_i == src_b_i)));
      pend_a = 1'b0;
      pend_b = 1'b0;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (src_a_i == IDX_W'(i)) pend_a = busy_q[i] & ~byp_a;
         if (src_b_i == IDX_W'(i)) pend_b = busy_q[i] & ~byp_b;
      end
      hazard_o = rd_en_i & (pend_a | pend_b);
   end

   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/y86_regfile_fwd.sv
// Y86-64 register file: two registered read ports, E/M write ports with optional
// same-cycle bypass, and a busy scoreboard that flags unresolved RAW hazards.
module y86_regfile_fwd
   import y86_pkg::*;
#(
   parameter int unsigned        DATA_W = y86_pkg::DATA_W,
   parameter int unsigned        NREGS  = 15,
   parameter int unsigned        IDX_W  = 4,
   parameter logic [IDX_W-1:0]   RNONE  = IDX_W'(y86_pkg::RNONE),
   parameter bit                 BYPASS = 1'b1,
   parameter logic [DATA_W-1:0]  RST_R0 = DATA_W'(2),
   parameter logic [DATA_W-1:0]  RST_R1 = DATA_W'(3)
) (
   input  logic              clk_i,
   input  logic              res_i,
   input  logic              rd_en_i,
   input  logic [IDX_W-1:0]  src_a_i,
   input  logic [IDX_W-1:0]  src_b_i,
   output logic [DATA_W-1:0] val_a_o,
   output logic [DATA_W-1:0] val_b_o,
   input  logic [IDX_W-1:0]  dst_e_i,
   input  logic [DATA_W-1:0] val_e_i,
   input  logic [IDX_W-1:0]  dst_m_i,
   input  logic [DATA_W-1:0] val_m_i,
   input  logic              iss_en_i,
   input  logic [IDX_W-1:0]  iss_dst_e_i,
   input  logic [IDX_W-1:0]  iss_dst_m_i,
   output logic              hazard_o,
   input  logic [IDX_W-1:0]  dbg_idx_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   if ((64'd1 << IDX_W) <= 64'(NREGS)) begin : g_idx_w_check
      $error("IDX_W too narrow: 2**IDX_W must exceed NREGS");
   end
   if (int'(RNONE) < int'(NREGS)) begin : g_rnone_check
      $error("RNONE must not address an architectural register");
   end

   localparam logic [IDX_W-1:0] NRegsIdx = IDX_W'(NREGS);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] val_a_q, val_a_d;
   logic [DATA_W-1:0] val_b_q, val_b_d;
   logic              we_e, we_m;

   // Loop-based select keeps out-of-range indices from ever addressing the array.
   function automatic logic [DATA_W-1:0] arr_read(input logic [IDX_W-1:0] idx,
                                                  input logic [DATA_W-1:0] arr [NREGS]);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (idx == IDX_W'(i)) r = arr[i];
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] port_read(input logic [IDX_W-1:0]  src,
                                                   input logic              e_ok,
                                                   input logic [IDX_W-1:0]  e_idx,
                                                   input logic [DATA_W-1:0] e_val,
                                                   input logic              m_ok,
                                                   input logic [IDX_W-1:0]  m_idx,
                                                   input logic [DATA_W-1:0] m_val,
                                                   input logic [DATA_W-1:0] arr [NREGS]);
      logic [DATA_W-1:0] r;
      if (src >= NRegsIdx) begin
         r = '0;
      end else if (BYPASS && m_ok && (m_idx == src)) begin
         r = m_val;
      end else if (BYPASS && e_ok && (e_idx == src)) begin
         r = e_val;
      end else begin
         r = arr_read(src, arr);
      end
      return r;
   endfunction

   always_comb begin
      we_e = dst_e_i < NRegsIdx;
      we_m = dst_m_i < NRegsIdx;
   end

   // M is applied after E so that it wins on a shared destination (popq %rsp).
   always_comb begin
      for (int i = 0; i < int'(NREGS); i++) begin
         regs_d[i] = regs_q[i];
         if (we_e && (dst_e_i == IDX_W'(i))) regs_d[i] = val_e_i;
         if (we_m && (dst_m_i == IDX_W'(i))) regs_d[i] = val_m_i;
      end
   end

   always_comb begin
      val_a_d = port_read(src_a_i, we_e, dst_e_i, val_e_i, we_m, dst_m_i, val_m_i, regs_q);
      val_b_d = port_read(src_b_i, we_e, dst_e_i, val_e_i, we_m, dst_m_i, val_m_i, regs_q);
   end

   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= (i == 0) ? RST_R0 : (i == 1) ? RST_R1 : '0;
         end
      end else begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_ff @(posedge clk_i or posedge res_i) begin
      if (res_i) begin
         val_a_q <= '0;
         val_b_q <= '0;
      end else if (rd_en_i) begin
         val_a_q <= val_a_d;
         val_b_q <= val_b_d;
      end
   end

   always_comb begin
      val_a_o    = val_a_q;
      val_b_o    = val_b_q;
      dbg_data_o = arr_read(dbg_idx_i, regs_q);
   end

   y86_rf_scoreboard #(
      .NREGS  (NREGS),
      .IDX_W  (IDX_W),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk_i       (clk_i),
      .res_i       (res_i),
      .rd_en_i     (rd_en_i),
      .src_a_i     (src_a_i),
      .src_b_i     (src_b_i),
      .we_e_i      (we_e),
      .dst_e_i     (dst_e_i),
      .we_m_i      (we_m),
      .dst_m_i     (dst_m_i),
      .iss_en_i    (iss_en_i),
      .iss_dst_e_i (iss_dst_e_i),
      .iss_dst_m_i (iss_dst_m_i),
      .hazard_o    (hazard_o)
   );

endmodule

// File: tb/tb_y86_regfile_fwd.sv
// Bench for y86_regfile_fwd: a bypassing and a non-bypassing instance share stimulus and
// are compared against a register-array reference model.
module tb_y86_regfile_fwd;

   logic        clk = 1'b0;
   logic        res;
   logic        rd_en, iss_en;
   logic [3:0]  src_a, src_b, dst_e, dst_m, iss_dst_e, iss_dst_m, dbg_idx;
   logic [63:0] val_e, val_m;
   logic [63:0] va1, vb1, dbg1, va0, vb0, dbg0;
   logic        hz1, hz0;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] m_regs [15];
   bit          m_busy [15];
   logic [63:0] m_va1, m_vb1, m_va0, m_vb0;
   logic [63:0] snap [15];

   always #5 clk = ~clk;

   y86_regfile_fwd #(.BYPASS(1'b1)) dut (
      .clk_i(clk), .res_i(res), .rd_en_i(rd_en), .src_a_i(src_a), .src_b_i(src_b),
      .val_a_o(va1), .val_b_o(vb1), .dst_e_i(dst_e), .val_e_i(val_e), .dst_m_i(dst_m),
      .val_m_i(val_m), .iss_en_i(iss_en), .iss_dst_e_i(iss_dst_e), .iss_dst_m_i(iss_dst_m),
      .hazard_o(hz1), .dbg_idx_i(dbg_idx), .dbg_data_o(dbg1)
   );

   y86_regfile_fwd #(.BYPASS(1'b0)) dut_nb (
      .clk_i(clk), .res_i(res), .rd_en_i(rd_en), .src_a_i(src_a), .src_b_i(src_b),
      .val_a_o(va0), .val_b_o(vb0), .dst_e_i(dst_e), .val_e_i(val_e), .dst_m_i(dst_m),
      .val_m_i(val_m), .iss_en_i(iss_en), .iss_dst_e_i(iss_dst_e), .iss_dst_m_i(iss_dst_m),
      .hazard_o(hz0), .dbg_idx_i(dbg_idx), .dbg_data_o(dbg0)
   );

   // ---------------- reference model ----------------
   function automatic logic [63:0] m_read(input logic [3:0] s, input bit byp);
      if (s >= 4'd15) return 64'd0;
      if (byp && dst_m < 4'd15 && dst_m == s) return val_m;
      if (byp && dst_e < 4'd15 && dst_e == s) return val_e;
      return m_regs[s];
   endfunction

   function automatic bit m_pend(input logic [3:0] s, input bit byp);
      if (s >= 4'd15) return 1'b0;
      if (!m_busy[s]) return 1'b0;
      if (byp && ((dst_e < 4'd15 && dst_e == s) || (dst_m < 4'd15 && dst_m == s))) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_hazard(input bit byp);
      return rd_en && (m_pend(src_a, byp) || m_pend(src_b, byp));
   endfunction

   function automatic logic [63:0] m_dbg();
      return (dbg_idx < 4'd15) ? m_regs[dbg_idx] : 64'd0;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 15; i++) begin
         m_regs[i] = (i == 0) ? 64'd2 : (i == 1) ? 64'd3 : 64'd0;
         m_busy[i] = 1'b0;
      end
      m_va1 = 0; m_vb1 = 0; m_va0 = 0; m_vb0 = 0;
   endtask

   // Advance one clock edge and apply the architectural update rules to the model.
   task automatic clock_edge();
      @(posedge clk);
      if (rd_en) begin
         m_va1 = m_read(src_a, 1'b1); m_vb1 = m_read(src_b, 1'b1);
         m_va0 = m_read(src_a, 1'b0); m_vb0 = m_read(src_b, 1'b0);
      end
      if (dst_e < 4'd15) begin m_regs[dst_e] = val_e; m_busy[dst_e] = 1'b0; end
      if (dst_m < 4'd15) begin m_regs[dst_m] = val_m; m_busy[dst_m] = 1'b0; end
      if (iss_en && iss_dst_e < 4'd15) m_busy[iss_dst_e] = 1'b1;
      if (iss_en && iss_dst_m < 4'd15) m_busy[iss_dst_m] = 1'b1;
      #1;
   endtask

   task automatic set_idle();
      rd_en = 0; iss_en = 0; src_a = 4'hF; src_b = 4'hF;
      dst_e = 4'hF; dst_m = 4'hF; iss_dst_e = 4'hF; iss_dst_m = 4'hF;
      val_e = 0; val_m = 0; dbg_idx = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      res = 1'b1; set_idle(); m_reset();
      #1;
      vectors++;
      if ({va1, vb1, va0, vb0} !== 256'd0) begin
         miscompares++; $display("FAIL reset_vals got %h %h %h %h want 0", va1, vb1, va0, vb0);
      end
      repeat (2) @(posedge clk);
      #1 res = 1'b0;
      rd_en = 1; src_a = 4'd0; src_b = 4'd1; dbg_idx = 4'd5;
      #1;
      vectors++;
      if (hz1 !== 1'b0 || dbg1 !== 64'd0) begin
         miscompares++; $display("FAIL reset_hz_dbg got hz=%b dbg=%h want 0 0", hz1, dbg1);
      end
      clock_edge();
      vectors++;
      if (va1 !== 64'd2 || vb1 !== 64'd3 || va0 !== 64'd2 || vb0 !== 64'd3) begin
         miscompares++; $display("FAIL reset_read got %h %h %h %h want 2 3 2 3", va1, vb1, va0, vb0);
      end
      set_idle();
   endtask

   task automatic test_bypass_e();
      dst_e = 4'd3; val_e = 64'hAA; src_a = 4'd3; rd_en = 1;
      clock_edge();
      vectors++;
      if (va1 !== 64'hAA || va0 !== 64'd0) begin
         miscompares++; $display("FAIL bypass_e got byp=%h nobyp=%h want aa 0", va1, va0);
      end
      dst_e = 4'hF;
      clock_edge();
      vectors++;
      if (va0 !== 64'hAA) begin
         miscompares++; $display("FAIL bypass_e_later got %h want aa", va0);
      end
      set_idle();
   endtask

   task automatic test_same_dst();
      dst_e = 4'd4; val_e = 64'd100; dst_m = 4'd4; val_m = 64'd200; src_a = 4'd4; rd_en = 1;
      clock_edge();
      vectors++;
      if (va1 !== 64'd200 || va0 !== 64'd0) begin
         miscompares++; $display("FAIL same_dst_read got %0d %0d want 200 0", va1, va0);
      end
      set_idle(); dbg_idx = 4'd4;
      #1;
      vectors++;
      if (dbg1 !== 64'd200 || dbg0 !== 64'd200) begin
         miscompares++; $display("FAIL same_dst_reg got %0d %0d want 200", dbg1, dbg0);
      end
   endtask

   task automatic test_hazard();
      iss_en = 1; iss_dst_m = 4'd2;
      clock_edge();
      set_idle(); src_b = 4'd2; rd_en = 1;
      #1;
      vectors++;
      if (hz1 !== 1'b1 || hz0 !== 1'b1) begin
         miscompares++; $display("FAIL hazard_set got %b %b want 1 1", hz1, hz0);
      end
      dst_m = 4'd2; val_m = 64'd7;
      #1;
      vectors++;
      if (hz1 !== 1'b0 || hz0 !== 1'b1) begin
         miscompares++; $display("FAIL hazard_bypass got byp=%b nobyp=%b want 0 1", hz1, hz0);
      end
      clock_edge();
      vectors++;
      if (vb1 !== 64'd7 || vb0 !== 64'd0) begin
         miscompares++; $display("FAIL hazard_val got %0d %0d want 7 0", vb1, vb0);
      end
      dst_m = 4'hF;
      #1;
      vectors++;
      if (hz1 !== 1'b0 || hz0 !== 1'b0) begin
         miscompares++; $display("FAIL hazard_clear got %b %b want 0 0", hz1, hz0);
      end
      set_idle();
   endtask

   task automatic test_set_wins();
      iss_en = 1; iss_dst_e = 4'd6; dst_e = 4'd6; val_e = 64'd55;
      clock_edge();
      set_idle(); src_a = 4'd6; rd_en = 1;
      #1;
      vectors++;
      if (hz1 !== 1'b1 || hz0 !== 1'b1) begin
         miscompares++; $display("FAIL set_wins got %b %b want 1 1", hz1, hz0);
      end
      rd_en = 0; dst_e = 4'd6; val_e = 64'd56;
      clock_edge();
      set_idle();
   endtask

   task automatic test_invalid_writes();
      for (int i = 0; i < 15; i++) snap[i] = m_regs[i];
      dst_e = 4'hF; val_e = 64'hDEAD_BEEF_0123_4567; dst_m = 4'd15; val_m = 64'hFFFF_FFFF_FFFF_FFFF;
      clock_edge();
      set_idle();
      for (int i = 0; i < 15; i++) begin
         dbg_idx = 4'(i);
         #1;
         vectors++;
         if (dbg1 !== snap[i] || dbg0 !== snap[i]) begin
            miscompares++; $display("FAIL invalid_write r%0d got %h %h want %h", i, dbg1, dbg0, snap[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rd_en     = ($urandom_range(0, 3) != 0);
         iss_en    = ($urandom_range(0, 9) < 3);
         src_a     = 4'($urandom_range(0, 15));
         src_b     = 4'($urandom_range(0, 15));
         dst_e     = 4'($urandom_range(0, 15));
         dst_m     = 4'($urandom_range(0, 15));
         iss_dst_e = 4'($urandom_range(0, 15));
         iss_dst_m = 4'($urandom_range(0, 15));
         dbg_idx   = 4'($urandom_range(0, 15));
         val_e     = {$urandom, $urandom};
         val_m     = {$urandom, $urandom};
         #1;
         vectors++;
         if (hz1 !== m_hazard(1'b1) || hz0 !== m_hazard(1'b0)) begin
            miscompares++;
            $display("FAIL rand_hazard n=%0d got %b %b want %b %b", n, hz1, hz0,
                     m_hazard(1'b1), m_hazard(1'b0));
         end
         vectors++;
         if (dbg1 !== m_dbg() || dbg0 !== m_dbg()) begin
            miscompares++; $display("FAIL rand_dbg n=%0d got %h %h want %h", n, dbg1, dbg0, m_dbg());
         end
         clock_edge();
         vectors++;
         if ({va1, vb1, va0, vb0} !== {m_va1, m_vb1, m_va0, m_vb0}) begin
            miscompares++;
            $display("FAIL rand_read n=%0d got %h %h %h %h want %h %h %h %h", n, va1, vb1, va0, vb0,
                     m_va1, m_vb1, m_va0, m_vb0);
         end
      end
      set_idle();
   endtask

   task automatic test_reset_mid();
      iss_en = 1; iss_dst_e = 4'd9;
      clock_edge();
      set_idle(); src_a = 4'd9; rd_en = 1; dst_e = 4'd3; val_e = 64'h1234;
      #1;
      vectors++;
      if (hz1 !== 1'b1) begin
         miscompares++; $display("FAIL mid_pre_hazard got %b want 1", hz1);
      end
      #1 res = 1'b1;
      m_reset();
      #1;
      vectors++;
      if (hz1 !== 1'b0 || hz0 !== 1'b0 || va1 !== 64'd0 || va0 !== 64'd0) begin
         miscompares++; $display("FAIL mid_reset got hz=%b %b va=%h %h want 0", hz1, hz0, va1, va0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 15; i++) begin
         dbg_idx = 4'(i);
         #1;
         vectors++;
         if (dbg1 !== m_regs[i] || dbg0 !== m_regs[i]) begin
            miscompares++; $display("FAIL mid_reset_reg r%0d got %h %h want %h", i, dbg1, dbg0, m_regs[i]);
         end
      end
      set_idle();
      res = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bypass_e();
      test_same_dst();
      test_hazard();
      test_set_wins();
      test_invalid_writes();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/y86_regfile_fwd.md
Name: y86_regfile_fwd

Overview:
Parametrised Y86-64 register file. Successor to the single-port decode/writeback register bank.
- Two registered read ports (srcA/srcB) and two write ports (E-port from execute, M-port from memory).
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard that raises a load-use/RAW hazard flag for the pipeline control.
- Sits between the D and W stages of the PIPE datapath; replaces ad-hoc register arrays inside decode.

Parameters:
DATA_W, 64, register width in bits
NREGS, 15, number of architectural registers (indices 0..NREGS-1)
IDX_W, 4, register index width
RNONE, 4'hF, index meaning "no register"; must be >= NREGS
BYPASS, 1, 1 = a write in the same cycle is visible on the read ports; 0 = reads return the pre-write value
RST_R0, 2, reset value of register 0
RST_R1, 3, reset value of register 1 (all others reset to 0)

Ports:
clk  in  1  clock; all state updates on posedge
res  in  1  asynchronous active-high reset
rd_en  in  1  capture read results this cycle
srcA  in  IDX_W  read port A index
srcB  in  IDX_W  read port B index
valA  out  DATA_W  registered read data A
valB  out  DATA_W  registered read data B
dstE  in  IDX_W  E write index (RNONE = no write)
valE  in  DATA_W  E write data
dstM  in  IDX_W  M write index (RNONE = no write)
valM  in  DATA_W  M write data
iss_en  in  1  decode issue strobe; marks iss_dstE/iss_dstM busy
iss_dstE  in  IDX_W  future E destination being issued
iss_dstM  in  IDX_W  future M destination being issued
hazard  out  1  combinational: a requested source is pending and not resolvable this cycle
dbg_idx  in  IDX_W  debug read index
dbg_data  out  DATA_W  combinational debug read of the array, no bypass

Behaviour:
Reset (async, res=1):
- reg[0]=RST_R0, reg[1]=RST_R1, all others 0.
- busy[] all 0; valA=valB=0.
- Reset mid-operation discards pending writes and busy state immediately.

Write (posedge, res=0):
- An index is a valid write target only if < NREGS. RNONE and out-of-range indices are ignored.
- dstE==dstM (both valid): valM wins. This matches Y86 popq %rsp semantics.

Read (posedge, rd_en=1):
- 1-cycle latency: valA/valB update at the edge, visible the next cycle.
- rd_en=0: valA/valB hold.
- srcX invalid (RNONE or >= NREGS): valX <= 0.
- BYPASS=1 priority: dstM match -> valM; else dstE match -> valE; else reg[srcX].
- BYPASS=0: valX <= reg[srcX] pre-edge value.

Scoreboard:
- busy[i] is set at posedge when iss_en=1 and i equals a valid iss_dstE or iss_dstM.
- busy[i] is cleared at posedge when i is written via dstE or dstM.
- Set and clear of the same register in the same cycle: set wins (a newer producer is in flight).
- iss_en with both iss_dst = RNONE: no change.

Hazard:
- hazard = rd_en & (pendA | pendB).
- pendX = srcX valid & busy[srcX] & !(BYPASS & srcX matches a valid dstE/dstM this cycle).
- hazard has no reset dependency beyond busy.
- The block does not stall itself: on hazard it still captures valA/valB; the controller must repeat the read.

Width rules:
- No arithmetic.
- IDX_W must satisfy 2^IDX_W > NREGS; violation is an elaboration error.

Decomposition:
- Package y86_pkg holds:
  - Register index constants: RRSP=4, RNONE=4'hF, and the named registers 0..14.
  - Icode constants: IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11.
  - The DATA_W=64 default.
- One sub-module, y86_rf_scoreboard, holds the busy vector and hazard logic. The array, read ports and bypass stay in the top.

Test Plan:
1. Assert res, release; rd_en with srcA=0, srcB=1 -> next cycle valA=2, valB=3, hazard=0. dbg_idx=5 -> dbg_data=0.
2. dstE=3, valE=64'hAA and srcA=3, rd_en same cycle. BYPASS=1 -> valA=AA. BYPASS=0 -> valA=0 then AA on the next read.
3. dstE=4, valE=100 and dstM=4, valM=200 in the same cycle -> reg[4]=200. Reading srcA=4 in that same cycle with BYPASS=1 -> valA=200.
4. iss_en with iss_dstM=2; next cycle srcB=2, rd_en=1 -> hazard=1. Then dstM=2, valM=7 with srcB=2 -> hazard=0 (BYPASS=1) and valB=7.
5. iss_en with iss_dstE=6 in the same cycle as dstE=6 -> busy[6] stays 1. Reading srcA=6 next cycle -> hazard=1.
6. dstE=RNONE and dstM=15 with nonzero data -> no register changes (dbg sweep 0..14). Assert res mid-sequence with busy set -> hazard=0, regs back to 2/3/0.
